// File: rtl/io_input_ctrl_pkg.sv
// Shared constants for the memory-mapped input peripheral: register offsets,
// SoC placement, interrupt routing and small bus helpers.
package io_input_ctrl_pkg;

    localparam logic [3:0]  IN_DATA = 4'h0;
    localparam logic [3:0]  IN_PEND = 4'h4;
    localparam logic [3:0]  IN_MASK = 4'h8;
    localparam logic [3:0]  IN_EDGE = 4'hC;

    localparam logic [31:0] IO_INPUT_BASE    = 32'h1000_2000;
    localparam int unsigned IO_INPUT_IRQ_BIT = 3;

    // Word index of each register; only addr[3:2] is decoded.
    typedef enum logic [1:0] {
        REG_DATA = IN_DATA[3:2],
        REG_PEND = IN_PEND[3:2],
        REG_MASK = IN_MASK[3:2],
        REG_EDGE = IN_EDGE[3:2]
    } reg_sel_e;

    function automatic reg_sel_e decode_reg(input logic [3:0] addr);
        return reg_sel_e'(addr[3:2]);
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) begin
            m[8*b +: 8] = {8{sel[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/io_input_ctrl_debounce_bit.sv
// One input pin: synchroniser, debounce counter and accepted-level flop.
// rise_o/fall_o pulse in the cycle whose closing edge updates stable_o.
module debounce_bit #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W           = 18
) (
    input  logic clk,
    input  logic reset,
    input  logic pin_i,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_q;
    logic             sync_q;
    logic             level_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             differ;
    logic             accept;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
        cnt_d    = '0;
        stable_d = stable_q;
        differ   = (level_q != stable_q);
        accept   = differ && (cnt_q == CNT_LAST);
        if (accept) begin
            stable_d = level_q;
        end else if (differ) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // level_q follows the two-flop synchroniser so a new level is seen on
    // DEBOUNCE_CYCLES consecutive edges before it is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the synchroniser is reset too, so a pin held through reset must requalify from scratch.
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            level_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            // NOTE: non-blocking so each flop samples the pre-edge value; blocking would collapse the chain.
            meta_q   <= pin_i;
            sync_q   <= meta_q;
            level_q  <= sync_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;
    assign rise_o   = accept &  level_q;
    assign fall_o   = accept & ~level_q;

endmodule

// File: rtl/io_input_ctrl.sv
// Memory-mapped debounced input block: DATA/PEND/MASK/EDGE registers on the
// DMEM-style bus and a registered level interrupt to the core.
module io_input_ctrl
    import io_input_ctrl_pkg::*;
#(
    parameter int unsigned N_IN            = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W           = 18
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_IN-1:0] i_pins,
    input  logic [3:0]      i_addr,
    input  logic            i_we,
    input  logic [3:0]      i_sel,
    input  logic [31:0]     i_wdata,
    output logic [31:0]     o_rdata,
    output logic            o_int
);

    logic [N_IN-1:0] stable_w;
    logic [N_IN-1:0] rise_w;
    logic [N_IN-1:0] fall_w;

    for (genvar i = 0; i < N_IN; i++) begin : g_in
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_debounce (
            .clk      (clk),
            .reset    (reset),
            .pin_i    (i_pins[i]),
            .stable_o (stable_w[i]),
            .rise_o   (rise_w[i]),
            .fall_o   (fall_w[i])
        );
    end

    logic [N_IN-1:0] pend_q,    pend_d;
    logic [N_IN-1:0] mask_q,    mask_d;
    logic [N_IN-1:0] rise_en_q, rise_en_d;
    logic [N_IN-1:0] fall_en_q, fall_en_d;
    logic            int_q,     int_d;

    reg_sel_e        reg_sel;
    logic [31:0]     bmask;
    logic            wr_pend;
    logic            wr_mask;
    logic            wr_edge;
    logic [N_IN-1:0] pend_clr;
    logic [N_IN-1:0] pend_set;

    always_comb begin
        reg_sel   = decode_reg(i_addr);
        bmask     = lane_mask(i_sel);
        wr_pend   = i_we && (reg_sel == REG_PEND);
        wr_mask   = i_we && (reg_sel == REG_MASK);
        wr_edge   = i_we && (reg_sel == REG_EDGE);
        mask_d    = mask_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        pend_clr  = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (wr_mask && bmask[i])    mask_d[i]    = i_wdata[i];
            if (wr_edge && bmask[i])    rise_en_d[i] = i_wdata[i];
            if (wr_edge && bmask[16+i]) fall_en_d[i] = i_wdata[16+i];
            if (wr_pend && bmask[i])    pend_clr[i]  = i_wdata[i];
        end
        // A qualified edge in the same cycle as a W1C clear keeps the bit set.
        pend_set = (rise_w & rise_en_q) | (fall_w & fall_en_q);
        pend_d   = (pend_q & ~pend_clr) | pend_set;
        int_d    = |(pend_q & mask_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q    <= '0;
            mask_q    <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            int_q     <= 1'b0;
        end else begin
            pend_q    <= pend_d;
            mask_q    <= mask_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            int_q     <= int_d;
        end
    end

    always_comb begin
        o_rdata = '0;
        case (reg_sel)
            REG_DATA: o_rdata[N_IN-1:0] = stable_w;
            REG_PEND: o_rdata[N_IN-1:0] = pend_q;
            REG_MASK: o_rdata[N_IN-1:0] = mask_q;
            REG_EDGE: begin
                o_rdata[N_IN-1:0]  = rise_en_q;
                o_rdata[16 +: N_IN] = fall_en_q;
            end
            default:  o_rdata = '0;
        endcase
    end

    assign o_int = int_q;

endmodule

// File: tb/tb_io_input_ctrl.sv
// Directed bench for io_input_ctrl with DEBOUNCE_CYCLES=4: reset state,
// debounce latency, glitch rejection, W1C/byte lanes, set-wins and reset mid-debounce.
`timescale 1ns/1ps
module tb_io_input_ctrl;
    import io_input_ctrl_pkg::*;

    localparam int N_IN = 16;
    localparam int DEB  = 4;
    localparam int CW   = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic [N_IN-1:0] i_pins;
    logic [3:0]      i_addr;
    logic            i_we;
    logic [3:0]      i_sel;
    logic [31:0]     i_wdata;
    logic [31:0]     o_rdata;
    logic            o_int;

    int checks   = 0;
    int failures = 0;

    always #10 clk = ~clk;

    io_input_ctrl #(
        .N_IN            (N_IN),
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (CW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .i_pins  (i_pins),
        .i_addr  (i_addr),
        .i_we    (i_we),
        .i_sel   (i_sel),
        .i_wdata (i_wdata),
        .o_rdata (o_rdata),
        .o_int   (o_int)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reg(input string tag, input logic [3:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        i_addr = addr;
        #1;
        d = o_rdata;
        check(tag, d, exp);
    endtask

    task automatic bus_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] sel);
        i_addr  = addr;
        i_wdata = data;
        i_sel   = sel;
        i_we    = 1'b1;
        tick();
        i_we    = 1'b0;
        i_sel   = 4'h0;
        i_wdata = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog timeout");
    end

    initial begin
        reset   = 1'b1;
        i_pins  = '0;
        i_addr  = '0;
        i_we    = 1'b0;
        i_sel   = 4'h0;
        i_wdata = '0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        check_reg("rst_data", IN_DATA, 32'h0);
        check_reg("rst_pend", IN_PEND, 32'h0);
        check_reg("rst_mask", IN_MASK, 32'h0);
        check_reg("rst_edge", IN_EDGE, 32'h0);
        check("rst_int", {31'b0, o_int}, 32'h0);

        // Pin 3 step: visible after edge 6, not earlier; EDGE=0 so no PEND
        i_pins[3] = 1'b1;
        for (int e = 0; e <= 6; e++) begin
            tick();
            check_reg($sformatf("lat_data_e%0d", e), IN_DATA, (e >= 6) ? 32'h8 : 32'h0);
        end
        check_reg("lat_pend", IN_PEND, 32'h0);

        // Glitch of 3 cycles on pin 0 is rejected
        bus_write(IN_EDGE, 32'h0000_0001, 4'hF);
        bus_write(IN_MASK, 32'h0000_0001, 4'hF);
        check_reg("cfg_edge", IN_EDGE, 32'h1);
        check_reg("cfg_mask", IN_MASK, 32'h1);
        i_pins[0] = 1'b1;
        repeat (3) tick();
        i_pins[0] = 1'b0;
        for (int e = 0; e < 8; e++) begin
            tick();
            check_reg($sformatf("glitch_data_%0d", e), IN_DATA, 32'h8);
        end
        check_reg("glitch_pend", IN_PEND, 32'h0);

        // Held high: DATA[0] and PEND[0] on edge 6, o_int on edge 7
        i_pins[0] = 1'b1;
        for (int e = 0; e <= 6; e++) begin
            tick();
            check_reg($sformatf("rise_data_e%0d", e), IN_DATA, (e >= 6) ? 32'h9 : 32'h8);
            check_reg($sformatf("rise_pend_e%0d", e), IN_PEND, (e >= 6) ? 32'h1 : 32'h0);
            check($sformatf("rise_int_e%0d", e), {31'b0, o_int}, 32'h0);
        end
        tick();
        check("rise_int_e7", {31'b0, o_int}, 32'h1);

        // W1C: no lanes selected leaves PEND; lane 0 clears, o_int drops a cycle later
        bus_write(IN_PEND, 32'h0000_0001, 4'b0000);
        check_reg("w1c_nosel_pend", IN_PEND, 32'h1);
        check("w1c_nosel_int", {31'b0, o_int}, 32'h1);
        bus_write(IN_PEND, 32'h0000_0001, 4'b0001);
        check_reg("w1c_pend", IN_PEND, 32'h0);
        check("w1c_int_same", {31'b0, o_int}, 32'h1);
        tick();
        check("w1c_int_next", {31'b0, o_int}, 32'h0);

        // Unimplemented bits read 0; byte lanes act independently
        bus_write(IN_MASK, 32'hFFFF_FFFF, 4'hF);
        check_reg("mask_full", IN_MASK, 32'h0000_FFFF);
        bus_write(IN_MASK, 32'h0000_0000, 4'b0010);
        check_reg("mask_lane1", IN_MASK, 32'h0000_00FF);
        bus_write(IN_DATA, 32'hFFFF_FFFF, 4'hF);
        check_reg("data_ro", IN_DATA, 32'h9);
        bus_write(IN_MASK, 32'h0000_0001, 4'hF);

        // Fall on pin 5 coinciding with a W1C clear: the set wins
        i_pins[5] = 1'b1;
        repeat (8) tick();
        check_reg("fall_pre_data", IN_DATA, 32'h29);
        bus_write(IN_EDGE, 32'h0020_0000, 4'hF);
        check_reg("fall_edge", IN_EDGE, 32'h0020_0000);
        i_pins[5] = 1'b0;
        repeat (6) tick();
        check_reg("fall_e5_data", IN_DATA, 32'h29);
        bus_write(IN_PEND, 32'h0000_0020, 4'hF);
        check_reg("setwins_pend", IN_PEND, 32'h20);
        check_reg("setwins_data", IN_DATA, 32'h09);
        check("setwins_int", {31'b0, o_int}, 32'h0);
        bus_write(IN_PEND, 32'h0000_0020, 4'b0001);
        check_reg("setwins_clr", IN_PEND, 32'h0);

        // Reset in the middle of qualifying pin 1
        i_pins = 16'h0002;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check_reg("mrst_data", IN_DATA, 32'h0);
        tick();
        reset = 1'b0;
        check_reg("mrst_mask", IN_MASK, 32'h0);
        check_reg("mrst_edge", IN_EDGE, 32'h0);
        check("mrst_int", {31'b0, o_int}, 32'h0);
        for (int e = 0; e <= 6; e++) begin
            tick();
            check_reg($sformatf("mrst_data_e%0d", e), IN_DATA, (e >= 6) ? 32'h2 : 32'h0);
        end
        check_reg("mrst_pend", IN_PEND, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
